pw_gen: RTL

PW_GEN -- requirements
Module: pw_gen

---
 rtl/pw_pkg.sv | 14 +
 rtl/pw_scale.sv | 21 ++
 rtl/pw_gen.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pw_pkg.sv
// Shared state encoding and default parameter values for the pulse-width generator.
package pw_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } pw_state_e;

    localparam logic [31:0] DEF_TICKS_PER_UNIT = 32'd1;
    localparam logic [31:0] DEF_GAP_CYCLES     = 32'd4;
    localparam logic [31:0] DEF_MAX_TICKS      = 32'hFFFF_FFFF;

endpackage

// File: rtl/pw_scale.sv
// Converts a requested width in units into a pulse length in clk cycles,
// saturating at MAX_TICKS. Purely combinational.
module pw_scale
    import pw_pkg::*;
#(
    parameter logic [31:0] TICKS_PER_UNIT = DEF_TICKS_PER_UNIT,
    parameter logic [31:0] MAX_TICKS      = DEF_MAX_TICKS
) (
    input  logic [31:0] width_in,
    output logic [31:0] ticks
);

    logic [63:0] product;

    always_comb begin
        // Full 64-bit product so large widths clamp instead of wrapping.
        product = {32'd0, width_in} * {32'd0, TICKS_PER_UNIT};
        ticks   = (product > {32'd0, MAX_TICKS}) ? MAX_TICKS : product[31:0];
    end

endmodule

// File: rtl/pw_gen.sv
// Pulse-width generator: emits one PW-high pulse per accepted width, followed by
// a fixed low gap, optionally reissuing the last width back-to-back.
module pw_gen
    import pw_pkg::*;
#(
    parameter logic [31:0] TICKS_PER_UNIT = DEF_TICKS_PER_UNIT,
    parameter logic [31:0] GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter logic [31:0] MAX_TICKS      = DEF_MAX_TICKS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] width_in,
    input  logic        width_valid,
    output logic        width_ready,
    input  logic        repeat_en,
    output logic        PW,
    output logic        busy,
    output logic        done,
    output logic [15:0] pulse_count
);

    pw_state_e   state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] last_ticks_q, last_ticks_d;
    logic        pw_q, pw_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic [15:0] pulse_count_q, pulse_count_d;

    logic [31:0] ticks;
    logic        final_gap;
    logic        accept;

    pw_scale #(
        .TICKS_PER_UNIT(TICKS_PER_UNIT),
        .MAX_TICKS     (MAX_TICKS)
    ) u_scale (
        .width_in(width_in),
        .ticks   (ticks)
    );

    // cnt_q counts down the remaining cycles of the current HIGH or GAP phase.
    assign final_gap   = (state_q == GAP) && (cnt_q == 32'd0);
    assign width_ready = (state_q == IDLE) || final_gap;
    assign accept      = width_valid && width_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_ticks_d  = last_ticks_q;
        done_d        = 1'b0;
        pulse_count_d = pulse_count_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            HIGH: begin
                if (cnt_q == 32'd0) begin
                    state_d       = GAP;
                    cnt_d         = GAP_CYCLES - 32'd1;
                    done_d        = 1'b1;
                    pulse_count_d = pulse_count_q + 16'd1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            GAP: begin
                if (cnt_q != 32'd0) begin
                    cnt_d = cnt_q - 32'd1;
                end else if (repeat_en && (last_ticks_q != 32'd0)) begin
                    state_d = HIGH;
                    cnt_d   = last_ticks_q - 32'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 32'd0;
            end
        endcase

        // A new request overrides the repeat decision in the final gap cycle.
        if (accept) begin
            last_ticks_d = ticks;
            if (ticks != 32'd0) begin
                state_d = HIGH;
                cnt_d   = ticks - 32'd1;
            end else begin
                state_d = IDLE;
                cnt_d   = 32'd0;
            end
        end

        pw_d   = (state_d == HIGH);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= 32'd0;
            last_ticks_q  <= 32'd0;
            pw_q          <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            pulse_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_ticks_q  <= last_ticks_d;
            pw_q          <= pw_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            pulse_count_q <= pulse_count_d;
        end
    end

    assign PW          = pw_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign pulse_count = pulse_count_q;

endmodule
